mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-ported instruction/data memory between instruction fetch and the execution-stage load/store path. It arbitrates requests, sequences one outstanding memory transaction at a time through a request/grant/response FSM, and aligns store data and byte enables. It sign- or zero-extends load data and drives the data-side stall that feeds the pipeline hazard logic.

Parameters:
MAX_D_RUN, 4, max consecutive data grants while fetch is pending before fetch is forced a grant (1..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held stable until if_done
if_addr  input  32  fetch word address (bits [1:0] ignored, driven as 0 to memory)
if_done  output  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  output  32  fetched instruction
d_req  input  1  load/store request; held stable until d_done or d_err
d_minst  input  4  {store, funct3}: 0xx load (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU), 1xx store (000 SB, 001 SH, 010 SW)
d_addr  input  32  byte address
d_wdata  input  32  store data, right-aligned
d_done  output  1  one-cycle pulse: data access complete
d_rdata  output  32  extended load result, valid with d_done
d_err  output  1  one-cycle pulse: misaligned or illegal funct3, no memory access
d_busy  output  1  d_req & !d_done & !d_err (combinational); stall to hazard logic
mem_req  output  1  memory request
mem_we  output  1  write enable
mem_addr  output  32  word-aligned address
mem_be  output  4  byte enables
mem_wdata  output  32  lane-aligned store data
mem_gnt  input  1  memory accepted request this cycle
mem_rvalid  input  1  response/write-ack valid (never before the cycle after mem_gnt)
mem_rdata  input  32  read data

Behaviour:
- Reset: state IDLE, run counter 0; mem_req, mem_we, if_done, d_done, d_err = 0; mem_be = 0; mem_addr/mem_wdata = 0.
- FSM states: IDLE, REQ_F, REQ_D, RSP_F, RSP_D.
- IDLE arbitration (per cycle): if d_req pending and (not if_req or run < MAX_D_RUN) -> data wins; else if if_req -> fetch wins. A data win with misaligned address (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or funct3 not listed: d_err pulses that cycle, state stays IDLE, no mem_req.
- Winner's address/be/wdata/we are registered; next cycle state REQ_F/REQ_D with mem_req=1. Minimum latency from request to done: 3 cycles (arbitrate, req+gnt, rvalid).
- REQ_x: hold mem_req and all mem_* stable until mem_gnt; on mem_gnt go to RSP_x, mem_req=0.
- RSP_x: wait for mem_rvalid; on it pulse if_done/d_done for that cycle, go to IDLE. Stores also complete on mem_rvalid (write ack).
- Run counter: +1 (saturating at MAX_D_RUN) on each data grant while if_req is high; cleared on fetch grant or when if_req is low at a data grant.
- Store alignment: SB be = 1<<addr[1:0], wdata byte replicated to all lanes; SH be = 0011 or 1100 by addr[1], halfword replicated; SW be = 1111.
- Loads: mem_we=0, mem_be=1111; result = mem_rdata shifted right by 8*addr[1:0], then LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
- mem_rvalid in IDLE/REQ_x is ignored. Reset in any state aborts immediately to IDLE; responses to aborted transactions are dropped.
- if_done and d_done are never both high in the same cycle.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, gnt 1 cycle later, rvalid next with 0x00000013 -> if_done at cycle 3, if_rdata=0x00000013, mem_addr=0x100, mem_be=1111.
- LB at 0x203 with mem_rdata=0x80FF_0000 -> d_rdata=0xFFFFFF80; LBU same -> 0x00000080; LH at 0x202 -> 0xFFFF80FF.
- SB d_addr=0x1001, d_wdata=0x000000AB -> mem_be=0010, mem_wdata=0xABABABAB, mem_we=1; SH at 0x1002 with 0x1234 -> be=1100, wdata=0x12341234.
- Both requesting continuously, MAX_D_RUN=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- LW at 0x2002 -> d_err pulse same cycle as arbitration, no mem_req, d_busy low that cycle.
- Reset asserted in RSP_D, mem_rvalid arrives next cycle -> no d_done, state IDLE, mem_req=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory port arbiter, its two requesters
// (instruction fetch and the load/store unit) and the shared memory.
//
// Modports:
//   slave  - the arbiter's view: takes requests and memory responses,
//            drives completions, load results and the memory request.
//   master - the environment's view: fetch/LSU requesters plus memory.
//
// Signal groups:
//   if_*   fetch request/completion
//   d_*    load/store request/completion, error pulse and stall
//   mem_*  single-ported memory request/grant/response
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;

    logic        d_req;
    logic [3:0]  d_minst;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        d_busy;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_minst, d_addr, d_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        output if_done, if_rdata, d_done, d_rdata, d_err, d_busy,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_minst, d_addr, d_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        input  if_done, if_rdata, d_done, d_rdata, d_err, d_busy,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the
// load/store path. One transaction is outstanding at a time; data wins
// arbitration until it has taken MAX_D_RUN grants in a row while fetch
// waits, then fetch is forced through. Store data/byte enables are lane
// aligned on the way out, load data is shifted and extended on the way in.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    mem_port_arbiter_if.slave (fetch, load/store and memory buses)
//
// state | meaning
// IDLE  | arbitrating; d_err pulses here for a bad data request
// REQ_F | fetch request presented, waiting for mem_gnt
// REQ_D | data request presented, waiting for mem_gnt
// RSP_F | fetch accepted, waiting for mem_rvalid
// RSP_D | data accepted, waiting for mem_rvalid (read data or write ack)
module mem_port_arbiter #(
    parameter int unsigned MAX_D_RUN = 4
) (
    input logic          clk,
    input logic          reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [2:0] {IDLE, REQ_F, REQ_D, RSP_F, RSP_D} state_t;

    localparam logic [3:0] RUN_MAX = 4'(MAX_D_RUN);

    state_t      state, state_nxt;
    logic [3:0]  run_cnt;

    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic        mem_we_q;
    logic [1:0]  d_lo_q;
    logic [2:0]  d_f3_q;

    logic        d_store;
    logic [2:0]  d_f3;
    logic        f3_ok;
    logic        misaligned;
    logic        d_bad;
    logic        d_win;
    logic        grant_d;
    logic        grant_f;
    logic        d_err_c;
    logic        if_done_c;
    logic        d_done_c;
    logic        mem_req_c;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_shift;
    logic [31:0] ld_result;
    logic        unused_addr_bits;

    assign d_store = bus.d_minst[3];
    assign d_f3    = bus.d_minst[2:0];

    // Word addresses only; the fetch low bits never reach memory.
    assign unused_addr_bits = ^bus.if_addr[1:0];

    always_comb begin
        f3_ok      = 1'b0;
        misaligned = 1'b0;
        if (d_store) begin
            f3_ok = (d_f3 == 3'b000) || (d_f3 == 3'b001) || (d_f3 == 3'b010);
        end else begin
            f3_ok = (d_f3 == 3'b000) || (d_f3 == 3'b001) || (d_f3 == 3'b010) ||
                    (d_f3 == 3'b100) || (d_f3 == 3'b101);
        end
        // funct3[1:0] selects access size for both loads and stores.
        if (d_f3[1:0] == 2'b01 && bus.d_addr[0]) begin
            misaligned = 1'b1;
        end
        if (d_f3[1:0] == 2'b10 && bus.d_addr[1:0] != 2'b00) begin
            misaligned = 1'b1;
        end
        d_bad = !f3_ok || misaligned;
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = bus.d_wdata;
        case (d_f3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << bus.d_addr[1:0];
                st_wdata = {4{bus.d_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{bus.d_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = bus.d_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        d_win     = 1'b0;
        grant_d   = 1'b0;
        grant_f   = 1'b0;
        d_err_c   = 1'b0;
        if_done_c = 1'b0;
        d_done_c  = 1'b0;
        mem_req_c = 1'b0;
        case (state)
            IDLE: begin
                d_win = bus.d_req && (!bus.if_req || run_cnt < RUN_MAX);
                if (d_win) begin
                    if (d_bad) begin
                        d_err_c = 1'b1;
                    end else begin
                        grant_d   = 1'b1;
                        state_nxt = REQ_D;
                    end
                end else if (bus.if_req) begin
                    grant_f   = 1'b1;
                    state_nxt = REQ_F;
                end
            end
            REQ_F: begin
                mem_req_c = 1'b1;
                if (bus.mem_gnt) begin
                    state_nxt = RSP_F;
                end
            end
            REQ_D: begin
                mem_req_c = 1'b1;
                if (bus.mem_gnt) begin
                    state_nxt = RSP_D;
                end
            end
            RSP_F: begin
                if (bus.mem_rvalid) begin
                    if_done_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RSP_D: begin
                if (bus.mem_rvalid) begin
                    d_done_c  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // While reset is held the old state must not leak any pulse.
        if (reset) begin
            d_err_c   = 1'b0;
            if_done_c = 1'b0;
            d_done_c  = 1'b0;
            grant_d   = 1'b0;
            grant_f   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            d_lo_q      <= '0;
            d_f3_q      <= '0;
        end else if (grant_f) begin
            mem_addr_q  <= {bus.if_addr[31:2], 2'b00};
            mem_be_q    <= 4'b1111;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else if (grant_d) begin
            mem_addr_q  <= {bus.d_addr[31:2], 2'b00};
            mem_be_q    <= d_store ? st_be : 4'b1111;
            mem_wdata_q <= d_store ? st_wdata : 32'h0;
            mem_we_q    <= d_store;
            d_lo_q      <= bus.d_addr[1:0];
            d_f3_q      <= d_f3;
        end
    end

    // Counts data grants taken while fetch is waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (grant_f) begin
            run_cnt <= '0;
        end else if (grant_d) begin
            if (!bus.if_req) begin
                run_cnt <= '0;
            end else if (run_cnt != RUN_MAX) begin
                run_cnt <= run_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        ld_shift  = bus.mem_rdata >> {d_lo_q, 3'b000};
        ld_result = ld_shift;
        case (d_f3_q)
            3'b000:  ld_result = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_result = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_result = {24'h0, ld_shift[7:0]};
            3'b101:  ld_result = {16'h0, ld_shift[15:0]};
            default: ld_result = ld_shift;
        endcase
    end

    assign bus.mem_req   = mem_req_c;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_done   = if_done_c;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_done    = d_done_c;
    assign bus.d_rdata   = ld_result;
    assign bus.d_err     = d_err_c;
    assign bus.d_busy    = bus.d_req && !d_done_c && !d_err_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset values, fetch, load
// extension, store alignment, fair arbitration, error pulse, reset abort.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_D_RUN(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // One data access with an immediate grant and a response the cycle after.
    task automatic run_data(input string tag, input logic [3:0] minst,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic exp_we,
                            input logic [31:0] exp_rdata, input logic is_store);
        bus.d_req   = 1'b1;
        bus.d_minst = minst;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        sample();
        check({tag, "_arb_busy"}, 32'(bus.d_busy), 32'd1);
        check({tag, "_arb_err"}, 32'(bus.d_err), 32'd0);
        step();
        bus.mem_gnt = 1'b1;
        sample();
        check({tag, "_req"}, 32'(bus.mem_req), 32'd1);
        check({tag, "_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        check({tag, "_be"}, 32'(bus.mem_be), 32'(exp_be));
        check({tag, "_we"}, 32'(bus.mem_we), 32'(exp_we));
        if (is_store) check({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        sample();
        check({tag, "_done"}, 32'(bus.d_done), 32'd1);
        check({tag, "_if_done"}, 32'(bus.if_done), 32'd0);
        check({tag, "_busy_done"}, 32'(bus.d_busy), 32'd0);
        if (!is_store) check({tag, "_rdata"}, bus.d_rdata, exp_rdata);
        step();
        bus.d_req      = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset          = 1'b1;
        bus.if_req     = 1'b0;
        bus.if_addr    = 32'h0;
        bus.d_req      = 1'b0;
        bus.d_minst    = 4'h0;
        bus.d_addr     = 32'h0;
        bus.d_wdata    = 32'h0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        sample();
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_be", 32'(bus.mem_be), 32'd0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        check("rst_if_done", 32'(bus.if_done), 32'd0);
        check("rst_d_done", 32'(bus.d_done), 32'd0);
        check("rst_d_err", 32'(bus.d_err), 32'd0);
        step();
        reset = 1'b0;

        // Fetch only
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0100;
        sample();
        check("f_arb_req", 32'(bus.mem_req), 32'd0);
        check("f_arb_done", 32'(bus.if_done), 32'd0);
        step();
        bus.mem_gnt = 1'b1;
        sample();
        check("f_req", 32'(bus.mem_req), 32'd1);
        check("f_addr", bus.mem_addr, 32'h0000_0100);
        check("f_be", 32'(bus.mem_be), 32'hF);
        check("f_we", 32'(bus.mem_we), 32'd0);
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0013;
        sample();
        check("f_done", 32'(bus.if_done), 32'd1);
        check("f_rdata", bus.if_rdata, 32'h0000_0013);
        check("f_rsp_req", 32'(bus.mem_req), 32'd0);
        check("f_d_done", 32'(bus.d_done), 32'd0);
        step();
        bus.if_req     = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        sample();
        check("f_done_clr", 32'(bus.if_done), 32'd0);
        step();

        // Loads
        run_data("lb",  4'b0000, 32'h203,  32'h0, 32'h80FF_0000, 4'hF, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b0);
        run_data("lbu", 4'b0100, 32'h203,  32'h0, 32'h80FF_0000, 4'hF, 32'h0, 1'b0, 32'h0000_0080, 1'b0);
        run_data("lh",  4'b0001, 32'h202,  32'h0, 32'h80FF_0000, 4'hF, 32'h0, 1'b0, 32'hFFFF_80FF, 1'b0);
        run_data("lhu", 4'b0101, 32'h202,  32'h0, 32'h80FF_0000, 4'hF, 32'h0, 1'b0, 32'h0000_80FF, 1'b0);
        run_data("lw",  4'b0010, 32'h204,  32'h0, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        run_data("lb0", 4'b0000, 32'h200,  32'h0, 32'h0000_007F, 4'hF, 32'h0, 1'b0, 32'h0000_007F, 1'b0);
        // Stores
        run_data("sb",  4'b1000, 32'h1001, 32'h0000_00AB, 32'h0, 4'b0010, 32'hABAB_ABAB, 1'b1, 32'h0, 1'b1);
        run_data("sb3", 4'b1000, 32'h1003, 32'h1234_56CD, 32'h0, 4'b1000, 32'hCDCD_CDCD, 1'b1, 32'h0, 1'b1);
        run_data("sh",  4'b1001, 32'h1002, 32'h0000_1234, 32'h0, 4'b1100, 32'h1234_1234, 1'b1, 32'h0, 1'b1);
        run_data("sh0", 4'b1001, 32'h1000, 32'hFFFF_5678, 32'h0, 4'b0011, 32'h5678_5678, 1'b1, 32'h0, 1'b1);
        run_data("sw",  4'b1010, 32'h1004, 32'hCAFE_F00D, 32'h0, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b1);

        // Misaligned LW
        bus.d_req   = 1'b1;
        bus.d_minst = 4'b0010;
        bus.d_addr  = 32'h2002;
        sample();
        check("lw_mis_err", 32'(bus.d_err), 32'd1);
        check("lw_mis_busy", 32'(bus.d_busy), 32'd0);
        check("lw_mis_req", 32'(bus.mem_req), 32'd0);
        step();
        bus.d_req = 1'b0;
        sample();
        check("lw_mis_req2", 32'(bus.mem_req), 32'd0);
        check("lw_mis_err2", 32'(bus.d_err), 32'd0);
        step();

        // Misaligned LH, illegal store funct3
        bus.d_req   = 1'b1;
        bus.d_minst = 4'b0001;
        bus.d_addr  = 32'h2001;
        sample();
        check("lh_mis_err", 32'(bus.d_err), 32'd1);
        step();
        bus.d_minst = 4'b1100;
        bus.d_addr  = 32'h2000;
        sample();
        check("st_ill_err", 32'(bus.d_err), 32'd1);
        step();
        bus.d_req = 1'b0;
        sample();
        check("st_ill_req", 32'(bus.mem_req), 32'd0);
        step();

        // Both requesting continuously: D,D,D,D,F,D,D,D,D,F
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0400;
        bus.d_req   = 1'b1;
        bus.d_minst = 4'b0010;
        bus.d_addr  = 32'h0000_0800;
        for (int k = 0; k < 10; k++) begin
            sample();
            check($sformatf("arb%0d_idle", k), 32'(bus.mem_req), 32'd0);
            step();
            bus.mem_gnt = 1'b1;
            sample();
            check($sformatf("arb%0d_addr", k), bus.mem_addr,
                  (k % 5 == 4) ? 32'h0000_0400 : 32'h0000_0800);
            step();
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'h1111_2222;
            sample();
            check($sformatf("arb%0d_if_done", k), 32'(bus.if_done), 32'((k % 5) == 4));
            check($sformatf("arb%0d_d_done", k), 32'(bus.d_done), 32'((k % 5) != 4));
            step();
            bus.mem_rvalid = 1'b0;
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        step();
        step();

        // Reset while waiting for the data response
        bus.d_req   = 1'b1;
        bus.d_minst = 4'b0010;
        bus.d_addr  = 32'h0000_3000;
        step();
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        reset       = 1'b1;
        sample();
        check("abort_rst_done", 32'(bus.d_done), 32'd0);
        step();
        reset          = 1'b0;
        bus.d_req      = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5555_AAAA;
        sample();
        check("abort_d_done", 32'(bus.d_done), 32'd0);
        check("abort_if_done", 32'(bus.if_done), 32'd0);
        check("abort_req", 32'(bus.mem_req), 32'd0);
        check("abort_addr", bus.mem_addr, 32'h0);
        step();
        bus.mem_rvalid = 1'b0;
        // Back in IDLE: a fresh fetch goes straight to request.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0900;
        step();
        sample();
        check("abort_fetch_req", 32'(bus.mem_req), 32'd1);
        check("abort_fetch_addr", bus.mem_addr, 32'h0000_0900);
        bus.if_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
